ram_writer: RTL and testbench



---
 rtl/ram_writer.sv | 197 +++++++++++++++++++
 tb/tb_ram_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_writer.sv
// -----------------------------------------------------------------------------
// ram_writer
//
// Write-side companion to the board's small lookup memory. Holds a
// DATA_WIDTH x 2**ADDR_WIDTH RAM that is loaded from switch inputs and
// exposes a registered read port for the LED/LCD debug displays.
//
// Two write modes, each started by a rising edge on its request line:
//   - single write : one cycle, writes wr_data to wr_addr
//   - fill         : DEPTH cycles, writes (seed ^ address) to every address,
//                    seed being wr_data captured at the request edge
//
// Ports:
//   clk_2      in   system clock
//   reset      in   asynchronous, active-high reset (clears RAM too)
//   wr_req     in   single-write request (level; rising edge acts)
//   fill_req   in   fill request (level; rising edge acts)
//   wr_addr    in   target address for a single write
//   wr_data    in   write data; also the fill seed
//   rd_addr    in   read address
//   rd_data    out  registered mem[rd_addr], 1-cycle latency, read-before-write
//   busy       out  high while in WRITE or FILL
//   done       out  one-cycle pulse after the final write of an operation
//   last_addr  out  address of the most recent word written
//   last_data  out  data of the most recent word written
//   wr_count   out  total words written, wraps modulo 2**CNT_WIDTH
// -----------------------------------------------------------------------------
module ram_writer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t                state_q;

    // Request edge detection
    logic                  wr_req_q;
    logic                  fill_req_q;
    logic                  wr_rise;
    logic                  fill_rise;

    // Operands captured at the request edge
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;     // single-write data or fill seed
    logic [ADDR_WIDTH-1:0] fill_cnt_q;

    // Registered outputs
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [DATA_WIDTH-1:0] last_data_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port, decoded from the current state
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign wr_rise   = wr_req   & ~wr_req_q;
    assign fill_rise = fill_req & ~fill_req_q;

    // -------------------------------------------------------------------------
    // Write port decode. During FILL the counter doubles as the address; the
    // size cast zero-extends it (or keeps its low bits when it is wider than
    // a data word) before it is mixed into the seed.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = data_q;
        case (state_q)
            WRITE: begin
                mem_we = 1'b1;
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_waddr = fill_cnt_q;
                mem_wdata = data_q ^ DATA_WIDTH'(fill_cnt_q);
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered status outputs.
    // Request flops sample every cycle regardless of state, so a level held
    // through a busy period never produces a late rise.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_req_q    <= 1'b0;
            fill_req_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            fill_cnt_q  <= '0;
            done_q      <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
            wr_count_q  <= '0;
        end else begin
            wr_req_q   <= wr_req;
            fill_req_q <= fill_req;
            done_q     <= 1'b0;

            if (mem_we) begin
                last_addr_q <= mem_waddr;
                last_data_q <= mem_wdata;
                wr_count_q  <= wr_count_q + CNT_WIDTH'(1);
            end

            case (state_q)
                IDLE: begin
                    // Fill has priority; a coincident write rise is dropped.
                    if (fill_rise) begin
                        fill_cnt_q <= '0;
                        data_q     <= wr_data;
                        state_q    <= FILL;
                    end else if (wr_rise) begin
                        addr_q     <= wr_addr;
                        data_q     <= wr_data;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                FILL: begin
                    if (fill_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RAM and read register. Both are updated on the same edge with
    // non-blocking assignments, which gives read-before-write behaviour when
    // rd_addr matches the address being written.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign busy      = (state_q == WRITE) || (state_q == FILL);
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign last_addr = last_addr_q;
    assign last_data = last_data_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_ram_writer.sv
module tb_ram_writer;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic       wr_req;
    logic       fill_req;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;
    logic [1:0] last_addr;
    logic [3:0] last_data;
    logic [7:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_mem [4];

    ram_writer #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(4),
        .CNT_WIDTH (8)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .wr_req   (wr_req),
        .fill_req (fill_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .last_addr(last_addr),
        .last_data(last_data),
        .wr_count (wr_count)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Read every address and compare against exp_mem (1-cycle latency).
    task automatic read_sweep(input string tag);
        for (int a = 0; a < 4; a++) begin
            rd_addr = a[1:0];
            tick();
            check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(exp_mem[a]));
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_req   = 1'b0;
        fill_req = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        tick();
        tick();
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_rd",    32'(rd_data),  32'd0);
        reset = 1'b0;

        // Memory is all zero after reset
        for (int a = 0; a < 4; a++) exp_mem[a] = 4'h0;
        read_sweep("rst");

        // ---- single write: mem[2] = 9 ----
        wr_addr = 2'd2;
        wr_data = 4'b1001;
        rd_addr = 2'd2;
        wr_req  = 1'b1;
        tick();
        check("wr_busy1", 32'(busy), 32'd1);
        check("wr_done0", 32'(done), 32'd0);
        wr_data = 4'hF;   // must not affect the latched data
        tick();
        check("wr_busy0",  32'(busy),      32'd0);
        check("wr_done1",  32'(done),      32'd1);
        check("wr_count",  32'(wr_count),  32'd1);
        check("wr_laddr",  32'(last_addr), 32'd2);
        check("wr_ldata",  32'(last_data), 32'd9);
        check("wr_rd_old", 32'(rd_data),   32'd0);
        tick();
        check("wr_done_clr", 32'(done),    32'd0);
        check("wr_rd_new",   32'(rd_data), 32'd9);
        wr_req = 1'b0;

        // ---- fill with seed 3 -> {3,2,1,0} ----
        wr_data  = 4'b0011;
        fill_req = 1'b1;
        tick();
        wr_data = 4'hC;   // changed mid-fill: must be ignored
        for (int c = 0; c < 4; c++) begin
            check($sformatf("fill_busy%0d", c), 32'(busy), 32'd1);
            check($sformatf("fill_nodone%0d", c), 32'(done), 32'd0);
            tick();
        end
        check("fill_busy_end", 32'(busy),      32'd0);
        check("fill_done",     32'(done),      32'd1);
        check("fill_count",    32'(wr_count),  32'd5);
        check("fill_laddr",    32'(last_addr), 32'd3);
        check("fill_ldata",    32'(last_data), 32'd0);
        fill_req = 1'b0;
        tick();
        check("fill_done_clr", 32'(done), 32'd0);
        exp_mem[0] = 4'h3; exp_mem[1] = 4'h2; exp_mem[2] = 4'h1; exp_mem[3] = 4'h0;
        read_sweep("fill");

        // ---- simultaneous rises: fill wins, seed 5 -> {5,4,7,6} ----
        wr_addr  = 2'd1;
        wr_data  = 4'h5;
        wr_req   = 1'b1;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("sim_done",  32'(done),     32'd1);
        check("sim_count", 32'(wr_count), 32'd9);
        // wr_req still held high: nothing further happens
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("sim_hold_busy%0d", c), 32'(busy), 32'd0);
        end
        check("sim_hold_count", 32'(wr_count), 32'd9);
        wr_req = 1'b0;
        exp_mem[0] = 4'h5; exp_mem[1] = 4'h4; exp_mem[2] = 4'h7; exp_mem[3] = 4'h6;
        read_sweep("sim");

        // ---- reset in the middle of a fill ----
        wr_data  = 4'hA;
        fill_req = 1'b1;
        tick();           // enter FILL
        tick();           // addr 0 written
        tick();           // addr 1 written
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy",  32'(busy),      32'd0);
        check("mid_done",  32'(done),      32'd0);
        check("mid_count", 32'(wr_count),  32'd0);
        check("mid_laddr", 32'(last_addr), 32'd0);
        check("mid_ldata", 32'(last_data), 32'd0);
        check("mid_rd",    32'(rd_data),   32'd0);
        fill_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mid_nodone%0d", c), 32'(done), 32'd0);
        end
        for (int a = 0; a < 4; a++) exp_mem[a] = 4'h0;
        read_sweep("mid");

        // New write after reset release; also read-before-write on addr 1
        rd_addr = 2'd1;
        wr_addr = 2'd1;
        wr_data = 4'h7;
        wr_req  = 1'b1;
        tick();
        check("post_busy", 32'(busy), 32'd1);
        tick();
        check("post_done",  32'(done),     32'd1);
        check("post_count", 32'(wr_count), 32'd1);
        check("rbw_old",    32'(rd_data),  32'd0);
        tick();
        check("rbw_new",    32'(rd_data),  32'd7);
        wr_req = 1'b0;

        // ---- 256 single writes from reset: counter wraps ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 255; n++) begin
            wr_addr = n[1:0];
            wr_data = n[3:0];
            wr_req  = 1'b1;
            tick();
            wr_req  = 1'b0;
            tick();
        end
        check("wrap_255", 32'(wr_count), 32'd255);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        check("wrap_0",    32'(wr_count),  32'd0);
        check("wrap_done", 32'(done),      32'd1);
        check("wrap_ldata", 32'(last_data), 32'(4'hE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
